pc_wr_v1: RTL



---
 rtl/pc_wr_v1.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pc_wr_v1.sv
// Write-direction port controller: packs array result words MSB-first into bus
// words and issues one {P_ID, address} write request per bus-token grant.
module pc_wr_v1 #(
  parameter int         WIDTH_ARR = 16,
  parameter int         WIDTH_BUS = 64,
  parameter logic [5:0] P_ID      = 6'd0
) (
  input  logic                 clk_bus,
  input  logic                 rst_bus,
  input  logic                 start,
  input  logic [55:0]          config_bits,
  input  logic [WIDTH_ARR-1:0] wr_data_arr2pc,
  input  logic                 wr_data_arr2pc_en,
  input  logic                 tk_en,
  output logic                 pc_ready,
  output logic                 wr_req_en,
  output logic [33:0]          wr_req_out,
  output logic [WIDTH_BUS-1:0] wr_data_pc2mem,
  output logic                 done
);

  localparam int P2S_FACT       = WIDTH_BUS / WIDTH_ARR;
  localparam int WIDTH_MEM_ADDR = 28;
  localparam int WIDTH_REQ      = 34;
  localparam int LANE_W         = (P2S_FACT > 1) ? $clog2(P2S_FACT) : 1;
  localparam int FIFO_DEPTH     = 4;
  localparam int ENTRY_W        = WIDTH_REQ + WIDTH_BUS;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(P2S_FACT - 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t                    state_reg;
  logic [WIDTH_MEM_ADDR-1:0] base_reg;
  logic [WIDTH_MEM_ADDR-1:0] offset_reg;
  logic [WIDTH_MEM_ADDR-1:0] word_count_reg;
  logic [LANE_W-1:0]         lane_reg;
  logic [WIDTH_BUS-1:0]      pack_reg;
  logic [WIDTH_BUS-1:0]      pack_next;
  logic [ENTRY_W-1:0]        fifo_mem [FIFO_DEPTH];
  logic [1:0]                wr_ptr_reg;
  logic [1:0]                rd_ptr_reg;
  logic [2:0]                count_reg;

  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      accept;
  logic                      last_lane;
  logic                      push;
  logic                      pop;
  logic [WIDTH_MEM_ADDR-1:0] abs_addr;
  logic [ENTRY_W-1:0]        push_entry;
  logic [ENTRY_W-1:0]        head_entry;

  // Full/empty come from the registered count, so a same-cycle pop never frees a push slot.
  assign fifo_full  = (count_reg == 3'd4);
  assign fifo_empty = (count_reg == 3'd0);
  assign pc_ready   = (state_reg == FILL) && !fifo_full;
  assign accept     = wr_data_arr2pc_en && pc_ready;
  assign last_lane  = (lane_reg == LAST_LANE);
  assign push       = accept && last_lane;
  assign pop        = tk_en && !fifo_empty;
  assign abs_addr   = base_reg + word_count_reg;
  assign push_entry = {P_ID, abs_addr, pack_next};
  assign head_entry = fifo_mem[rd_ptr_reg];

  // Incoming word overlays its lane so the final lane is pushed in the same edge.
  generate
    for (genvar gi = 0; gi < P2S_FACT; gi++) begin : g_lane
      assign pack_next[WIDTH_BUS-1-gi*WIDTH_ARR -: WIDTH_ARR] =
        (lane_reg == LANE_W'(gi)) ? wr_data_arr2pc
                                  : pack_reg[WIDTH_BUS-1-gi*WIDTH_ARR -: WIDTH_ARR];
    end
  endgenerate

  always_ff @(posedge clk_bus) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk_bus or negedge rst_bus) begin
    if (!rst_bus) begin
      state_reg      <= IDLE;
      base_reg       <= '0;
      offset_reg     <= '0;
      word_count_reg <= '0;
      lane_reg       <= '0;
      pack_reg       <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      wr_req_en      <= 1'b0;
      wr_req_out     <= '0;
      wr_data_pc2mem <= '0;
      done           <= 1'b0;
    end else begin
      done           <= 1'b0;
      wr_req_en      <= pop;
      wr_req_out     <= pop ? head_entry[ENTRY_W-1 -: WIDTH_REQ] : '0;
      wr_data_pc2mem <= pop ? head_entry[WIDTH_BUS-1:0] : '0;

      if (push) wr_ptr_reg <= wr_ptr_reg + 2'd1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 2'd1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 3'd1;
        2'b01:   count_reg <= count_reg - 3'd1;
        default: count_reg <= count_reg;
      endcase

      if (accept) begin
        pack_reg <= pack_next;
        lane_reg <= last_lane ? '0 : lane_reg + LANE_W'(1);
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg      <= FILL;
            base_reg       <= config_bits[55:28];
            offset_reg     <= config_bits[27:0];
            word_count_reg <= '0;
            lane_reg       <= '0;
          end
        end
        FILL: begin
          if (push) begin
            word_count_reg <= word_count_reg + 28'd1;
            if (word_count_reg == offset_reg) state_reg <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state_reg <= IDLE;
            done      <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
